// File: rtl/wheel_encoder_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wheel_encoder_counter_pkg
// Description : Shared types and constants for the wheel encoder counter and
//               the downstream PID stage (count width, direction encoding,
//               quadrature Gray states, step decode helper).
// Revision    : 1.0 - initial release
// ============================================================================
package wheel_encoder_counter_pkg;

  localparam int CNT_W = 24;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Direction states double as the wheel_dir encoding seen by the PID stage.
  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_state_e;

  // Quadrature Gray states in forward order {A,B}.
  localparam logic [1:0] GRAY_S0 = 2'b00;
  localparam logic [1:0] GRAY_S1 = 2'b01;
  localparam logic [1:0] GRAY_S2 = 2'b11;
  localparam logic [1:0] GRAY_S3 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

  // Next Gray state in the forward direction.
  function automatic logic [1:0] gray_next(input logic [1:0] s);
    logic [1:0] n;
    n = GRAY_S0;
    case (s)
      GRAY_S0: n = GRAY_S1;
      GRAY_S1: n = GRAY_S2;
      GRAY_S2: n = GRAY_S3;
      default: n = GRAY_S0;
    endcase
    return n;
  endfunction

  // Classify a transition between two filtered {A,B} samples.
  function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_e r;
    r = STEP_NONE;
    if ((prev ^ cur) == 2'b11)
      r = STEP_ERR;
    else if (cur == gray_next(prev))
      r = STEP_FWD;
    else if (prev == gray_next(cur))
      r = STEP_REV;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wheel_encoder_counter_input_filter.sv
`default_nettype none
// ============================================================================
// Module      : enc_input_filter
// Description : One-bit conditioner for a raw encoder channel: 2-flop
//               synchronizer followed by a glitch filter that accepts a new
//               level only after FILTER_LEN consecutive differing cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_input_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       filt_q,  filt_d;
  logic [3:0] run_q,   run_d;

  // Synchronizer stages, filtered level and stability run counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      run_q   <= 4'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      run_q   <= run_d;
    end
  end

  // Count cycles the synchronized level disagrees with the filtered level;
  // the FILTER_LEN-th such cycle commits the new level.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    run_d   = 4'd0;
    if (sync2_q != filt_q) begin
      if (run_q == 4'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
        run_d  = 4'd0;
      end else begin
        run_d = run_q + 4'd1;
      end
    end
  end

  assign dout = filt_q;

endmodule
`default_nettype wire

// File: rtl/wheel_encoder_counter.sv
`default_nettype none
// ============================================================================
// Module      : wheel_encoder_counter
// Description : Quadrature decoder, saturating tick counter and hysteretic
//               direction tracker for one wheel encoder feeding the PID stage.
// Revision    : 1.0 - initial release
// ============================================================================
module wheel_encoder_counter
  import wheel_encoder_counter_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int DIR_HYST   = 2,
  parameter bit SWAP_AB    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             count_en,
  input  logic             zero_cnt,
  output logic [CNT_W-1:0] feedback_cnt,
  output logic             wheel_dir,
  output logic             step_pulse,
  output logic             quad_err,
  output logic             cnt_sat
);

  logic       chan_a, chan_b;
  logic       filt_a, filt_b;
  logic [1:0] cur_ab;
  step_e      step_kind;
  logic       step_valid;
  logic       step_opp;

  logic [1:0]       prev_ab_q, prev_ab_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             sat_q,     sat_d;
  logic             pulse_q,   pulse_d;
  logic             err_q,     err_d;
  dir_state_e       dir_q,     dir_d;
  logic [2:0]       pend_q,    pend_d;

  // Mirrored wheels swap channels so both sides count forward together.
  assign chan_a = SWAP_AB ? enc_b : enc_a;
  assign chan_b = SWAP_AB ? enc_a : enc_b;

  enc_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (chan_a),
    .dout (filt_a)
  );

  enc_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (chan_b),
    .dout (filt_b)
  );

  assign cur_ab     = {filt_a, filt_b};
  assign step_kind  = decode_step(prev_ab_q, cur_ab);
  assign step_valid = count_en && ((step_kind == STEP_FWD) || (step_kind == STEP_REV));
  assign step_opp   = (dir_q == DIR_FWD) ? (step_kind == STEP_REV) : (step_kind == STEP_FWD);

  // State register for decoder history, counter, pulses and direction FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ab_q <= GRAY_S0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      pulse_q   <= 1'b0;
      err_q     <= 1'b0;
      dir_q     <= DIR_FWD;
      pend_q    <= 3'd0;
    end else begin
      prev_ab_q <= prev_ab_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      pulse_q   <= pulse_d;
      err_q     <= err_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
    end
  end

  // Next-state logic: counting with zero priority, saturation, and the
  // direction FSM with opposite-step hysteresis.
  always_comb begin
    // History tracks every cycle so re-enabling counting sees no stale step.
    prev_ab_d = cur_ab;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    pulse_d   = 1'b0;
    err_d     = (step_kind == STEP_ERR);
    dir_d     = dir_q;
    pend_d    = pend_q;

    if (zero_cnt) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (step_valid) begin
      pulse_d = 1'b1;
      if (cnt_q != CNT_MAX)
        cnt_d = cnt_q + 1'b1;
      if (cnt_q >= CNT_MAX - 1'b1)
        sat_d = 1'b1;
    end

    if (step_kind == STEP_ERR) begin
      pend_d = 3'd0;
    end else if (step_valid) begin
      if (!step_opp) begin
        pend_d = 3'd0;
      end else if (pend_q + 3'd1 >= 3'(DIR_HYST)) begin
        pend_d = 3'd0;
        dir_d  = (dir_q == DIR_FWD) ? DIR_REV : DIR_FWD;
      end else begin
        pend_d = pend_q + 3'd1;
      end
    end
  end

  assign feedback_cnt = cnt_q;
  assign wheel_dir    = dir_q;
  assign step_pulse   = pulse_q;
  assign quad_err     = err_q;
  assign cnt_sat      = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_wheel_encoder_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wheel_encoder_counter
// Description : Directed self-checking bench for wheel_encoder_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wheel_encoder_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
  logic        count_en = 1'b1;
  logic        zero_cnt = 1'b0;
  logic [23:0] feedback_cnt;
  logic        wheel_dir;
  logic        step_pulse;
  logic        quad_err;
  logic        cnt_sat;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulse  = 0;
  int n_qerr   = 0;
  int idx      = 0;
  int p0;
  int q0;
  logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  wheel_encoder_counter #(
    .FILTER_LEN(4),
    .DIR_HYST  (2),
    .SWAP_AB   (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .count_en    (count_en),
    .zero_cnt    (zero_cnt),
    .feedback_cnt(feedback_cnt),
    .wheel_dir   (wheel_dir),
    .step_pulse  (step_pulse),
    .quad_err    (quad_err),
    .cnt_sat     (cnt_sat)
  );

  always #5 clk = ~clk;

  // Tally output pulses away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (step_pulse) n_pulse++;
      if (quad_err)   n_qerr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One quadrature step with 20-cycle spacing.
  task automatic step(input bit fwd);
    @(negedge clk);
    idx = fwd ? (idx + 1) % 4 : (idx + 3) % 4;
    {enc_a, enc_b} = gray_tab[idx];
    repeat (20) @(negedge clk);
  endtask

  task automatic pulse_zero();
    @(negedge clk);
    zero_cnt = 1'b1;
    @(negedge clk);
    zero_cnt = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cnt",   32'(feedback_cnt), 32'h0);
    check("rst_dir",   32'(wheel_dir),    32'h0);
    check("rst_pulse", 32'(step_pulse),   32'h0);
    check("rst_qerr",  32'(quad_err),     32'h0);
    check("rst_sat",   32'(cnt_sat),      32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Forward rotation: 32 steps
    for (int i = 0; i < 32; i++) step(1'b1);
    check("fwd_cnt",    32'(feedback_cnt), 32'd32);
    check("fwd_dir",    32'(wheel_dir),    32'h0);
    check("fwd_pulses", 32'(n_pulse),      32'd32);
    check("fwd_qerr",   32'(n_qerr),       32'd0);

    // Reversal with hysteresis
    pulse_zero();
    check("zero_cnt", 32'(feedback_cnt), 32'h0);
    for (int i = 0; i < 10; i++) step(1'b1);
    step(1'b0);
    check("rev1_dir", 32'(wheel_dir),    32'h0);
    check("rev1_cnt", 32'(feedback_cnt), 32'd11);
    @(negedge clk);
    idx = (idx + 3) % 4;
    {enc_a, enc_b} = gray_tab[idx];
    repeat (6) @(posedge clk);
    #1;
    check("rev2_early_pulse", 32'(step_pulse), 32'h0);
    check("rev2_early_dir",   32'(wheel_dir),  32'h0);
    @(posedge clk);
    #1;
    check("rev2_pulse", 32'(step_pulse),   32'h1);
    check("rev2_dir",   32'(wheel_dir),    32'h1);
    check("rev2_cnt",   32'(feedback_cnt), 32'd12);
    repeat (20) @(negedge clk);

    // Glitch rejection: three 3-cycle pulses on A, then one real step
    p0 = n_pulse;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      enc_a = 1'b1;
      repeat (3) @(negedge clk);
      enc_a = 1'b0;
      repeat (12) @(negedge clk);
    end
    check("glitch_cnt",    32'(feedback_cnt), 32'd12);
    check("glitch_pulses", 32'(n_pulse - p0), 32'd0);
    step(1'b0);
    check("stable_cnt",    32'(feedback_cnt), 32'd13);
    check("stable_pulses", 32'(n_pulse - p0), 32'd1);

    // Illegal transition 10 -> 01
    p0 = n_pulse;
    q0 = n_qerr;
    @(negedge clk);
    idx = 1;
    {enc_a, enc_b} = gray_tab[idx];
    repeat (20) @(negedge clk);
    check("illegal_qerr", 32'(n_qerr - q0),  32'd1);
    check("illegal_cnt",  32'(feedback_cnt), 32'd13);

    // count_en low: steps ignored, re-enable gives no spurious step
    @(negedge clk);
    count_en = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1);
    check("hold_cnt",    32'(feedback_cnt), 32'd13);
    check("hold_pulses", 32'(n_pulse - p0), 32'd0);
    @(negedge clk);
    count_en = 1'b1;
    repeat (20) @(negedge clk);
    check("reen_cnt",    32'(feedback_cnt), 32'd13);
    check("reen_pulses", 32'(n_pulse - p0), 32'd0);
    step(1'b1);
    check("reen_step_cnt", 32'(feedback_cnt), 32'd14);
    check("reen_step_dir", 32'(wheel_dir),    32'h1);

    // Saturation: preload near the top, then 3 steps
    @(negedge clk);
    force dut.cnt_q = 24'hFFFFFE;
    @(negedge clk);
    release dut.cnt_q;
    @(negedge clk);
    check("preload_cnt", 32'(feedback_cnt), 32'hFFFFFE);
    p0 = n_pulse;
    for (int i = 0; i < 3; i++) step(1'b1);
    check("sat_cnt",    32'(feedback_cnt), 32'hFFFFFF);
    check("sat_flag",   32'(cnt_sat),      32'h1);
    check("sat_pulses", 32'(n_pulse - p0), 32'd3);

    // zero_cnt coincident with a step
    p0 = n_pulse;
    @(negedge clk);
    idx = (idx + 1) % 4;
    {enc_a, enc_b} = gray_tab[idx];
    repeat (6) @(posedge clk);
    @(negedge clk);
    zero_cnt = 1'b1;
    @(posedge clk);
    #1;
    check("zs_cnt",   32'(feedback_cnt), 32'h0);
    check("zs_sat",   32'(cnt_sat),      32'h0);
    check("zs_pulse", 32'(step_pulse),   32'h0);
    @(negedge clk);
    zero_cnt = 1'b0;
    repeat (15) @(negedge clk);
    check("zs_pulses", 32'(n_pulse - p0), 32'd0);

    // Reset mid-count
    for (int i = 0; i < 17; i++) step(1'b1);
    check("pre_rst_cnt", 32'(feedback_cnt), 32'd17);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cnt",   32'(feedback_cnt), 32'h0);
    check("arst_dir",   32'(wheel_dir),    32'h0);
    check("arst_pulse", 32'(step_pulse),   32'h0);
    check("arst_qerr",  32'(quad_err),     32'h0);
    check("arst_sat",   32'(cnt_sat),      32'h0);
    idx = 0;
    {enc_a, enc_b} = gray_tab[idx];
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) step(1'b1);
    check("post_rst_cnt", 32'(feedback_cnt), 32'd4);
    check("post_rst_dir", 32'(wheel_dir),    32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
